// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: valid/ready bundle carrying instructions in and decoded immediates out
interface imm_gen_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate decoder with a 2-entry skid buffer
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  imm_gen_pipe_if.slave io
);
  typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J, F_SH, F_ILL} fmt_t;
  logic [31:0]      ins;
  fmt_t             fmt;
  logic [XLEN-1:0]  imm;
  logic             shift;
  logic             wide_sh;
  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [2:0]       skid_fmt;
  logic             skid_illegal;
  logic [TAG_W-1:0] skid_tag;
  logic             accept;
  logic             drain;
  assign ins         = io.in_instr;
  assign io.in_ready = !skid_valid;
  assign accept      = io.in_valid & !skid_valid;
  assign drain       = !io.out_valid | io.out_ready;
  always_comb begin
    shift   = ins[13:12] == 2'b01;
    wide_sh = XLEN == 64 && ins[6:0] == 7'h13;
    case (ins[6:0])
      7'h03, 7'h67, 7'h73: fmt = F_I;
      7'h13, 7'h1b:        fmt = shift ? F_SH : F_I;
      7'h23:               fmt = F_S;
      7'h63:               fmt = F_B;
      7'h37, 7'h17:        fmt = F_U;
      7'h6f:               fmt = F_J;
      7'h33, 7'h3b:        fmt = F_R;
      default:             fmt = F_ILL;
    endcase
    imm = fmt == F_I  ? XLEN'($signed(ins[31:20])) :
          fmt == F_S  ? XLEN'($signed({ins[31:25], ins[11:7]})) :
          fmt == F_B  ? XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})) :
          fmt == F_U  ? XLEN'($signed({ins[31:12], 12'b0})) :
          fmt == F_J  ? XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})) :
          fmt == F_SH ? XLEN'(wide_sh ? ins[25:20] : {1'b0, ins[24:20]}) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      io.out_valid   <= 1'b0;
      io.out_imm     <= '0;
      io.out_fmt     <= '0;
      io.out_illegal <= 1'b0;
      io.out_tag     <= '0;
      skid_valid     <= 1'b0;
    end else if (flush) begin
      io.out_valid <= 1'b0;
      skid_valid   <= 1'b0;
    end else if (drain) begin
      io.out_valid <= skid_valid | accept;
      if (skid_valid) begin
        io.out_imm     <= skid_imm;
        io.out_fmt     <= skid_fmt;
        io.out_illegal <= skid_illegal;
        io.out_tag     <= skid_tag;
        skid_valid     <= 1'b0;
      end else if (accept) begin
        io.out_imm     <= imm;
        io.out_fmt     <= fmt;
        io.out_illegal <= fmt == F_ILL;
        io.out_tag     <= io.in_tag;
      end
    end else if (accept) begin
      skid_valid   <= 1'b1;
      skid_imm     <= imm;
      skid_fmt     <= fmt;
      skid_illegal <= fmt == F_ILL;
      skid_tag     <= io.in_tag;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and randomized checks of imm_gen_pipe against a queue-based reference
module tb_imm_gen_pipe;
  localparam int XLEN  = 64;
  localparam int TAG_W = 8;
  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [7:0]  tag;
  } beat_t;
  logic  clk = 1'b0;
  logic  reset;
  logic  flush;
  beat_t q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  imm_gen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) io ();
  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .io(io)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  function automatic beat_t ref_beat(logic [31:0] ins, logic [7:0] tag);
    beat_t  b;
    longint x = longint'(ins);
    longint v = 0;
    int     op = int'(ins[6:0]);
    int     f3 = int'(ins[14:12]);
    b.fmt = 3'd7;
    if (op == 'h03 || op == 'h67 || op == 'h73) b.fmt = 3'd1;
    if (op == 'h13 || op == 'h1b) b.fmt = (f3 == 1 || f3 == 5) ? 3'd6 : 3'd1;
    if (op == 'h23) b.fmt = 3'd2;
    if (op == 'h63) b.fmt = 3'd3;
    if (op == 'h37 || op == 'h17) b.fmt = 3'd4;
    if (op == 'h6f) b.fmt = 3'd5;
    if (op == 'h33 || op == 'h3b) b.fmt = 3'd0;
    case (b.fmt)
      3'd1: begin v = x >> 20; if (v >= 2048) v -= 4096; end
      3'd2: begin v = ((x >> 25) << 5) + ((x >> 7) & 31); if (v >= 2048) v -= 4096; end
      3'd3: begin
        v = (((x >> 31) & 1) << 12) + (((x >> 7) & 1) << 11) + (((x >> 25) & 63) << 5) + (((x >> 8) & 15) << 1);
        if (v >= 4096) v -= 8192;
      end
      3'd4: begin v = x & 'hFFFFF000; if (v >= 64'sh80000000) v -= 64'sh100000000; end
      3'd5: begin
        v = (((x >> 31) & 1) << 20) + (((x >> 12) & 255) << 12) + (((x >> 20) & 1) << 11) + (((x >> 21) & 1023) << 1);
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      3'd6: v = (x >> 20) & (op == 'h13 ? 63 : 31);
      default: v = 0;
    endcase
    b.imm = v;
    b.ill = b.fmt == 3'd7;
    b.tag = tag;
    return b;
  endfunction
  task automatic cyc(logic v, logic [31:0] ins, logic [7:0] t, logic rdy, logic fl, logic rs);
    logic acc;
    @(negedge clk);
    chk("out_valid", io.out_valid, q.size() > 0);
    chk("in_ready", io.in_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("imm", io.out_imm, q[0].imm);
      chk("fmt", io.out_fmt, q[0].fmt);
      chk("illegal", io.out_illegal, q[0].ill);
      chk("tag", io.out_tag, q[0].tag);
    end
    io.in_valid  = v;
    io.in_instr  = ins;
    io.in_tag    = t;
    io.out_ready = rdy;
    flush        = fl;
    reset        = rs;
    acc = v && q.size() < 2;
    if (rs || fl) q.delete();
    else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (acc) q.push_back(ref_beat(ins, t));
    end
  endtask
  task automatic expect_out(string name, logic [63:0] imm, logic [2:0] fmt, logic ill);
    @(posedge clk);
    #1;
    chk({name, "_imm"}, io.out_imm, imm);
    chk({name, "_fmt"}, io.out_fmt, fmt);
    chk({name, "_ill"}, io.out_illegal, ill);
  endtask
  task automatic expect_idle(string name, logic zero);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, io.out_valid, 0);
    chk({name, "_ready"}, io.in_ready, 1);
    if (zero) begin
      chk({name, "_imm"}, io.out_imm, 0);
      chk({name, "_fmt"}, io.out_fmt, 0);
      chk({name, "_ill"}, io.out_illegal, 0);
      chk({name, "_tag"}, io.out_tag, 0);
    end
  endtask
  initial begin
    logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h1b, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h3b};
    reset = 1'b1;
    flush = 1'b0;
    io.in_valid  = 1'b0;
    io.in_instr  = '0;
    io.in_tag    = '0;
    io.out_ready = 1'b0;
    @(posedge clk);
    expect_idle("reset", 1'b1);
    cyc(1, 32'hFFF00093, 8'd1, 1, 0, 0);
    expect_out("addi", 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    cyc(1, 32'hFE000EE3, 8'd2, 1, 0, 0);
    expect_out("beq", 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
    cyc(1, 32'h800000B7, 8'd3, 1, 0, 0);
    expect_out("lui", 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0);
    cyc(1, 32'h03F09093, 8'd4, 1, 0, 0);
    expect_out("slli", 64'd63, 3'd6, 1'b0);
    cyc(1, 32'h0000007F, 8'd5, 1, 0, 0);
    expect_out("ill", 64'd0, 3'd7, 1'b1);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(i < 4, 32'h00100093 + (i << 20), 8'(i), i < 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'h00500013, 8'(10 + i), 0, 0, 0);
    cyc(1, 32'h00700013, 8'd99, 0, 1, 0);
    expect_idle("flush", 1'b0);
    for (int i = 0; i < 3; i++) cyc(1, 32'h00900013, 8'(20 + i), 0, 0, 0);
    cyc(1, 32'h00B00013, 8'd98, 0, 0, 1);
    expect_idle("midrst", 1'b1);
    cyc(1, 32'hFFF00093, 8'd7, 1, 0, 0);
    expect_out("post_rst", 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins = $urandom;
      int k = $urandom_range(0, 12);
      if (k < 12) ins[6:0] = ops[k];
      cyc($urandom_range(0, 3) != 0, ins, 8'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 63) == 0, $urandom_range(0, 127) == 0);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
